dispatcher: RTL
===============

DISPATCHER -- requirements
Module: dispatcher

Interface
REQ-001 Parameter MAX_DEPENDENCIES, default 256: width of each dependency vector.
REQ-002 Parameter NUM_LANES, default 4: number of execution lanes fed (2..8).
REQ-003 Parameter LANE_CREDITS, default 2: max in-flight transactions per lane (1..15).
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 s_axis_tvalid  in  1  upstream (batch stage output) transaction valid.
REQ-007 s_axis_tready  out  1  dispatcher accepts transaction.
REQ-008 s_axis_tdata_owner_programID  in  64  transaction owner ID.
REQ-009 s_axis_tdata_read_dependencies  in  MAX_DEPENDENCIES  read set.
REQ-010 s_axis_tdata_write_dependencies  in  MAX_DEPENDENCIES  write set.
REQ-011 m_axis_tvalid  out  NUM_LANES  one-hot per-lane valid.
REQ-012 m_axis_tready  in  NUM_LANES  per-lane ready.
REQ-013 m_axis_tdata_owner_programID  out  64  shared data bus to all lanes.
REQ-014 m_axis_tdata_read_dependencies / m_axis_tdata_write_dependencies  out  MAX_DEPENDENCIES each  shared.
REQ-015 lane_done  in  NUM_LANES  1-cycle pulse per lane: one transaction retired, returns one credit.
REQ-016 lane_credits_avail  out  NUM_LANES  bit i high when lane i credit > 0.
REQ-017 dispatched_count, completed_count, stall_cycles  out  32 each  performance counters.
REQ-018 credit_error  out  1  sticky credit-overflow flag.

Function
REQ-019 FSM states IDLE, SELECT, SEND; one transaction held in internal hold register.
REQ-020 IDLE: s_axis_tready=1; on s_axis_tvalid&&s_axis_tready capture all three data fields into hold register, go SELECT.
REQ-021 SELECT/SEND: s_axis_tready=0.
REQ-022 SELECT: choose first lane with credit>0 searching rr_ptr, rr_ptr+1, ... mod NUM_LANES; latch lane, go SEND; if none, stay SELECT and increment stall_cycles.
REQ-023 SEND: m_axis_tvalid = one-hot of latched lane; data bus = hold register; valid and data stable until m_axis_tready[lane].
REQ-024 On SEND handshake: credit[lane]--, rr_ptr = (lane+1) mod NUM_LANES, dispatched_count++, go IDLE.
REQ-025 m_axis_tready of non-selected lanes ignored; m_axis_tvalid all-zero outside SEND.
REQ-026 Latency: accept in cycle N -> m_axis_tvalid asserted in cycle N+2 when credit available; max throughput 1 per 3 cycles.
REQ-027 lane_done[i] increments credit[i] and completed_count; multiple lanes may pulse same cycle, completed_count adds popcount.
REQ-028 Dispatch handshake and lane_done on same lane same cycle: credit unchanged.
REQ-029 lane_done[i] with credit[i]==LANE_CREDITS (and no same-cycle dispatch): credit saturates, credit_error set until reset.
REQ-030 Credit freed in cycle N is usable by SELECT in cycle N+1.
REQ-031 All 32-bit counters wrap modulo 2^32.
REQ-032 Data bus outside SEND holds last hold-register value (don't care to consumers).

Reset
REQ-033 rst asserted: immediately state=IDLE, m_axis_tvalid=0, s_axis_tready=0, hold register discarded.
REQ-034 Reset values: credit[i]=LANE_CREDITS, lane_credits_avail all-ones, rr_ptr=0, counters 0, credit_error 0, data bus 0.
REQ-035 First cycle after rst deassertion: s_axis_tready=1.
REQ-036 Reset mid-SEND: transaction lost, not counted in dispatched_count.

Verification
REQ-037 Reset, then 4 transactions, all lanes ready -> delivered on lanes 0,1,2,3 in order; dispatched_count=4; valid 2 cycles after each accept.
REQ-038 Defaults, no lane_done, 9 transactions -> first 8 dispatched (2 per lane), 9th stalls in SELECT; stall_cycles increments each cycle; lane_done[0] pulse -> 9th goes to lane 0 next cycle.
REQ-039 Lane 1 tready held low 5 cycles in SEND -> m_axis_tvalid=4'b0010 and data stable all 5 cycles, s_axis_tready=0.
REQ-040 lane_done on lane 2 in same cycle as lane-2 handshake -> credit[2] unchanged; completed_count+1, dispatched_count+1.
REQ-041 lane_done[3] pulse with credit[3]=2 -> credit_error=1, stays 1 until rst; credit[3] remains 2.
REQ-042 rst asserted during SEND -> m_axis_tvalid=0 same cycle; after release all counters 0, rr_ptr=0, next transaction to lane 0.

Source files
------------

// File: rtl/dispatcher.sv
// dispatcher: holds one upstream transaction and issues it to the next lane with free credit, round-robin.
// Each lane has a credit counter that is spent on dispatch and returned by lane_done.
module dispatcher #(
  parameter int MAX_DEPENDENCIES = 256,
  parameter int NUM_LANES = 4,
  parameter int LANE_CREDITS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic s_axis_tvalid,
  output logic s_axis_tready,
  input  logic [63:0] s_axis_tdata_owner_programID,
  input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
  input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
  output logic [NUM_LANES-1:0] m_axis_tvalid,
  input  logic [NUM_LANES-1:0] m_axis_tready,
  output logic [63:0] m_axis_tdata_owner_programID,
  output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_write_dependencies,
  input  logic [NUM_LANES-1:0] lane_done,
  output logic [NUM_LANES-1:0] lane_credits_avail,
  output logic [31:0] dispatched_count,
  output logic [31:0] completed_count,
  output logic [31:0] stall_cycles,
  output logic credit_error
);
  localparam int LW = $clog2(NUM_LANES);
  typedef enum logic [1:0] {IDLE, SELECT, SEND} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] lane_q, lane_d, rr_q, rr_d, idx, pick;
  logic found, accept, hs;
  logic [3:0] credit_q [NUM_LANES];
  logic [3:0] credit_d [NUM_LANES];
  logic [NUM_LANES-1:0] sat;
  logic [63:0] own_q, own_d;
  logic [MAX_DEPENDENCIES-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0] disp_q, disp_d, comp_q, comp_d, stall_q, stall_d;
  logic err_q, err_d;

  assign accept = s_axis_tvalid && s_axis_tready;
  assign hs = state_q == SEND && m_axis_tready[lane_q];

  // First lane with credit, scanning upward from the round-robin pointer.
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = LW'((int'(rr_q) + k) % NUM_LANES);
      if (!found && credit_q[idx] != '0) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;

  always_comb
    state_d = state_q == IDLE ? (accept ? SELECT : IDLE) :
              state_q == SELECT ? (found ? SEND : SELECT) : (hs ? IDLE : SEND);

  always_comb begin
    s_axis_tready = state_q == IDLE && !rst;
    m_axis_tvalid = state_q == SEND ? NUM_LANES'(1) << lane_q : '0;
    m_axis_tdata_owner_programID = own_q;
    m_axis_tdata_read_dependencies = rd_q;
    m_axis_tdata_write_dependencies = wr_q;
    dispatched_count = disp_q;
    completed_count = comp_q;
    stall_cycles = stall_q;
    credit_error = err_q;
    lane_credits_avail = '0;
    for (int i = 0; i < NUM_LANES; i++) lane_credits_avail[i] = credit_q[i] != '0;
  end

  // A same-cycle dispatch and return on one lane cancel out.
  always_comb begin
    lane_d = state_q == SELECT && found ? pick : lane_q;
    rr_d = hs ? (lane_q == LW'(NUM_LANES - 1) ? '0 : lane_q + 1'b1) : rr_q;
    own_d = accept ? s_axis_tdata_owner_programID : own_q;
    rd_d = accept ? s_axis_tdata_read_dependencies : rd_q;
    wr_d = accept ? s_axis_tdata_write_dependencies : wr_q;
    disp_d = disp_q + 32'(hs);
    comp_d = comp_q + 32'($countones(lane_done));
    stall_d = stall_q + 32'(state_q == SELECT && !found);
    sat = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      sat[i] = lane_done[i] && !(hs && lane_q == LW'(i)) && credit_q[i] == 4'(LANE_CREDITS);
      credit_d[i] = lane_done[i] == (hs && lane_q == LW'(i)) ? credit_q[i] :
                    lane_done[i] ? (sat[i] ? credit_q[i] : credit_q[i] + 4'd1) : credit_q[i] - 4'd1;
    end
    err_d = err_q || |sat;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lane_q <= '0;
      rr_q <= '0;
      own_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      disp_q <= '0;
      comp_q <= '0;
      stall_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) credit_q[i] <= 4'(LANE_CREDITS);
    end else begin
      lane_q <= lane_d;
      rr_q <= rr_d;
      own_q <= own_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      disp_q <= disp_d;
      comp_q <= comp_d;
      stall_q <= stall_d;
      err_q <= err_d;
      for (int i = 0; i < NUM_LANES; i++) credit_q[i] <= credit_d[i];
    end
endmodule
